// File: rtl/elevator_scan_controller.sv
// SCAN (collective) elevator controller: latches floor requests into a pending mask and
// serves them while sweeping, with programmable floor-to-floor travel and door dwell times.
module elevator_scan_controller #(
   parameter int unsigned FLOORS        = 8,
   parameter int unsigned FW            = $clog2(FLOORS),
   parameter int unsigned TRAVEL_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLOORS-1:0] req,
   input  logic              door_hold,
   output logic [FW-1:0]     current_floor,
   output logic [1:0]        direction,
   output logic              door_open,
   output logic [FLOORS-1:0] pending,
   output logic              arrived
);
   localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      MOVING     = 2'd1,
      DOOR_OPEN  = 2'd2,
      DOOR_CLOSE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [FW-1:0]     floor_q, floor_d;
   logic              sweep_up_q, sweep_up_d;
   logic [FLOORS-1:0] pending_q, pending_d;
   logic [TW-1:0]     travel_q, travel_d;
   logic [DW-1:0]     door_q, door_d;
   logic              arrived_q, arrived_d;

   logic [FLOORS-1:0] req_eff;
   logic [FLOORS-1:0] clr;
   logic              open_entry;
   logic              here, above, below, beyond;

   function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < FLOORS; i++)
         if (i > 32'(f) && p[i]) r = 1'b1;
      return r;
   endfunction

   function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < FLOORS; i++)
         if (i < 32'(f) && p[i]) r = 1'b1;
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      floor_d    = floor_q;
      sweep_up_d = sweep_up_q;
      travel_d   = travel_q;
      door_d     = door_q;
      arrived_d  = 1'b0;
      req_eff    = req;
      clr        = '0;
      open_entry = 1'b0;
      beyond     = 1'b0;
      here       = pending_q[floor_q];
      above      = any_above(pending_q, floor_q);
      below      = any_below(pending_q, floor_q);

      case (state_q)
         IDLE: begin
            if (here) begin
               open_entry = 1'b1;
            end else if (sweep_up_q ? above : (above && !below)) begin
               sweep_up_d = 1'b1;
               travel_d   = TRAVEL_LOAD;
               state_d    = MOVING;
            end else if (below) begin
               sweep_up_d = 1'b0;
               travel_d   = TRAVEL_LOAD;
               state_d    = MOVING;
            end
         end
         MOVING: begin
            if (travel_q != '0) begin
               travel_d = travel_q - 1'b1;
            end else begin
               // Stop decision looks at the floor being entered on this same edge.
               floor_d = sweep_up_q ? floor_q + FW'(1) : floor_q - FW'(1);
               beyond  = sweep_up_q ? any_above(pending_q, floor_d)
                                    : any_below(pending_q, floor_d);
               if (pending_q[floor_d] || !beyond) open_entry = 1'b1;
               else                               travel_d   = TRAVEL_LOAD;
            end
         end
         DOOR_OPEN: begin
            req_eff[floor_q] = 1'b0;
            if (req[floor_q] || door_hold) door_d  = DOOR_LOAD;
            else if (door_q == '0)         state_d = DOOR_CLOSE;
            else                           door_d  = door_q - 1'b1;
         end
         DOOR_CLOSE: begin
            if (req[floor_q]) open_entry = 1'b1;
            else              state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (open_entry) begin
         state_d      = DOOR_OPEN;
         door_d       = DOOR_LOAD;
         arrived_d    = 1'b1;
         clr[floor_d] = 1'b1;
      end

      pending_d = (pending_q | req_eff) & ~clr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         floor_q    <= '0;
         sweep_up_q <= 1'b1;
         pending_q  <= '0;
         travel_q   <= '0;
         door_q     <= '0;
         arrived_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         floor_q    <= floor_d;
         sweep_up_q <= sweep_up_d;
         pending_q  <= pending_d;
         travel_q   <= travel_d;
         door_q     <= door_d;
         arrived_q  <= arrived_d;
      end
   end

   assign current_floor = floor_q;
   assign direction     = (state_q == MOVING) ? (sweep_up_q ? 2'b01 : 2'b10) : 2'b00;
   assign door_open     = (state_q == DOOR_OPEN);
   assign pending       = pending_q;
   assign arrived       = arrived_q;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: a cycle-level car model checked every cycle, plus
// directed scenarios with hand-computed timings and stop orders; a 2-floor build on the side.
module tb_elevator_scan_controller;
   localparam int FL = 8;
   localparam int T  = 4;
   localparam int D  = 8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       door_hold;
   logic [2:0] current_floor;
   logic [1:0] direction;
   logic       door_open;
   logic [7:0] pending;
   logic       arrived;

   logic [1:0] req2;
   logic       hold2;
   logic [0:0] floor2;
   logic [1:0] dir2;
   logic       door2;
   logic [1:0] pend2;
   logic       arr2;

   int tests = 0;
   int fails = 0;
   bit chk   = 0;
   int max2  = 0;

   elevator_scan_controller #(.FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .req(req), .door_hold(door_hold),
      .current_floor(current_floor), .direction(direction), .door_open(door_open),
      .pending(pending), .arrived(arrived)
   );

   elevator_scan_controller #(.FLOORS(2), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut2 (
      .clk(clk), .rst(rst), .req(req2), .door_hold(hold2),
      .current_floor(floor2), .direction(dir2), .door_open(door2),
      .pending(pend2), .arrived(arr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Car model: step_left>0 while travelling, open_left>0 while the door is open.
   typedef struct packed {
      int floor;
      int up;
      int pend;
      int step_left;
      int open_left;
      int closing;
      int arrived;
   } model_t;

   model_t m;

   function automatic int nearest(int mask, int from, bit up);
      if (up) begin
         for (int f = from; f < FL; f++)
            if (f >= 0 && ((mask >> f) & 1) != 0) return f;
      end else begin
         for (int f = from; f >= 0; f--)
            if (f < FL && ((mask >> f) & 1) != 0) return f;
      end
      return -1;
   endfunction

   function automatic model_t model_next(model_t s, logic r_rst, logic [7:0] r_req, logic r_hold);
      model_t n;
      int rr, nxt, tu, td;
      bit enter;
      n = s;
      n.arrived = 0;
      if (r_rst) begin
         n.floor = 0; n.up = 1; n.pend = 0; n.step_left = 0;
         n.open_left = 0; n.closing = 0;
         return n;
      end
      rr = int'(r_req);
      enter = 0;
      if (s.open_left > 0) begin
         rr = rr & ~(1 << s.floor);
         if (((int'(r_req) >> s.floor) & 1) != 0 || r_hold) n.open_left = D;
         else if (s.open_left == 1) begin n.open_left = 0; n.closing = 1; end
         else n.open_left = s.open_left - 1;
      end else if (s.closing != 0) begin
         n.closing = 0;
         if (((int'(r_req) >> s.floor) & 1) != 0) enter = 1;
      end else if (s.step_left > 0) begin
         if (s.step_left > 1) n.step_left = s.step_left - 1;
         else begin
            n.floor = s.floor + ((s.up != 0) ? 1 : -1);
            n.step_left = 0;
            nxt = nearest(s.pend, n.floor, s.up != 0);
            if (nxt < 0 || nxt == n.floor) enter = 1;
            else n.step_left = T;
         end
      end else begin
         if (((s.pend >> s.floor) & 1) != 0) enter = 1;
         else begin
            tu = nearest(s.pend, s.floor + 1, 1'b1);
            td = nearest(s.pend, s.floor - 1, 1'b0);
            if ((s.up != 0) ? (tu >= 0) : (td < 0 && tu >= 0)) begin
               n.up = 1; n.step_left = T;
            end else if (td >= 0) begin
               n.up = 0; n.step_left = T;
            end
         end
      end
      n.pend = s.pend | rr;
      if (enter) begin
         n.open_left = D;
         n.arrived = 1;
         n.pend = n.pend & ~(1 << n.floor);
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_next(m, rst, req, door_hold);

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         check("model_floor",   int'(current_floor), m.floor);
         check("model_dir",     int'(direction), (m.step_left > 0) ? ((m.up != 0) ? 1 : 2) : 0);
         check("model_door",    int'(door_open), (m.open_left > 0) ? 1 : 0);
         check("model_pending", int'(pending), m.pend);
         check("model_arrived", int'(arrived), m.arrived);
         if (int'(floor2) > max2) max2 <= int'(floor2);
      end
   end

   task automatic pulse(input logic [7:0] mask);
      req = mask;
      @(negedge clk);
      req = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_arrival(input int budget, output int fl);
      fl = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (arrived) begin
            fl = int'(current_floor);
            break;
         end
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int cnt, reached;
      cnt = 0;
      reached = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!door_open && direction == 2'b00 && pending == '0) cnt++;
         else cnt = 0;
         if (cnt >= 2) begin
            reached = 1;
            break;
         end
      end
      check(name, reached, 1);
   endtask

   // Starts on the arrival negedge (k=0); inputs driven at k are sampled on the next edge.
   task automatic measure_open(input int hold_from, input int hold_len, input int req_k,
                               input logic [7:0] rmask, output int n);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         if (!door_open) break;
         n++;
         door_hold = (k >= hold_from && k < hold_from + hold_len);
         req = (k == req_k) ? rmask : 8'h00;
         @(negedge clk);
      end
      door_hold = 1'b0;
      req = '0;
   endtask

   task automatic collect(input int want, input int budget, output int order[$]);
      order = {};
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (arrived) order.push_back(int'(current_floor));
         if (order.size() >= want) break;
      end
   endtask

   initial begin
      int first_arr, open_n, fl, reached, injected, n;
      int order[$];
      rst = 1'b1; req = '0; door_hold = 1'b0; req2 = '0; hold2 = 1'b0;
      @(negedge clk);
      chk = 1;
      @(negedge clk);
      check("rst_floor",   int'(current_floor), 0);
      check("rst_dir",     int'(direction), 0);
      check("rst_door",    int'(door_open), 0);
      check("rst_pending", int'(pending), 0);
      check("rst_arrived", int'(arrived), 0);
      rst = 1'b0;

      // Single request five floors up
      req = 8'h20;
      first_arr = -1;
      open_n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         req = '0;
         if (k == 1)  check("t2_pend_latched", int'(pending), 32);
         if (k == 2)  check("t2_dir_up", int'(direction), 1);
         if (k == 5)  check("t2_floor_k5", int'(current_floor), 0);
         if (k == 6)  check("t2_floor_k6", int'(current_floor), 1);
         if (k == 21) check("t2_floor_k21", int'(current_floor), 4);
         if (k == 22) begin
            check("t2_floor_k22", int'(current_floor), 5);
            check("t2_pend_k22", int'(pending), 0);
         end
         if (arrived && first_arr < 0) first_arr = k;
         if (door_open) open_n++;
      end
      check("t2_arrive_clk", first_arr, 22);
      check("t2_open_clks", open_n, 8);
      check("t2_idle_dir", int'(direction), 0);

      // Reset in the middle of a move
      do_reset();
      pulse(8'h80);
      reached = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (current_floor == 3'd3) begin
            reached = 1;
            break;
         end
      end
      check("t1_reach_floor3", reached, 1);
      rst = 1'b1;
      req = 8'hff;
      @(negedge clk);
      check("t1_floor", int'(current_floor), 0);
      check("t1_dir", int'(direction), 0);
      check("t1_pending", int'(pending), 0);
      check("t1_door", int'(door_open), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      req = '0;

      // Requests injected while passing floor 2
      pulse(8'h40);
      order = {};
      injected = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         req = '0;
         if (arrived) order.push_back(int'(current_floor));
         if (!injected && current_floor == 3'd2) begin
            req = 8'h12;
            injected = 1;
         end
         if (order.size() >= 3) break;
      end
      check("t3_stops", order.size(), 3);
      check("t3_stop0", (order.size() > 0) ? order[0] : -1, 4);
      check("t3_stop1", (order.size() > 1) ? order[1] : -1, 6);
      check("t3_stop2", (order.size() > 2) ? order[2] : -1, 1);
      wait_idle("t3_idle", 100);

      // Door hold and door-timer restart at floor 3
      do_reset();
      pulse(8'h08);
      wait_arrival(40, fl);
      check("t4_arrive_floor", fl, 3);
      measure_open(0, 20, -1, 8'h00, n);
      check("t4_hold_open_clks", n, 28);
      wait_idle("t4_idle_a", 20);
      pulse(8'h08);
      wait_arrival(10, fl);
      check("t4_reopen_floor", fl, 3);
      measure_open(-1, 0, 4, 8'h08, n);
      check("t4_restart_open_clks", n, 13);
      check("t4_pend_not_set", int'(pending), 0);
      wait_idle("t4_idle_b", 20);

      // Request at the idle floor, then re-request during DOOR_CLOSE
      do_reset();
      req = 8'h01;
      @(negedge clk);
      req = '0;
      check("t5_door_k1", int'(door_open), 0);
      @(negedge clk);
      check("t5_door_k2", int'(door_open), 1);
      check("t5_arrived1", int'(arrived), 1);
      check("t5_floor", int'(current_floor), 0);
      measure_open(-1, 0, -1, 8'h00, n);
      check("t5_open_clks", n, 8);
      check("t5_closing", int'(door_open), 0);
      req = 8'h01;
      @(negedge clk);
      req = '0;
      check("t5_arrived2", int'(arrived), 1);
      check("t5_reopen", int'(door_open), 1);
      check("t5_pend_clear", int'(pending), 0);
      measure_open(-1, 0, -1, 8'h00, n);
      check("t5_open_clks2", n, 8);
      wait_idle("t5_idle", 20);

      // Idle at 4 sweeping up, requests on both sides
      do_reset();
      pulse(8'h10);
      wait_arrival(60, fl);
      check("t6_at4", fl, 4);
      wait_idle("t6_idle", 30);
      pulse(8'h84);
      collect(2, 200, order);
      check("t6_stops", order.size(), 2);
      check("t6_stop0", (order.size() > 0) ? order[0] : -1, 7);
      check("t6_stop1", (order.size() > 1) ? order[1] : -1, 2);
      wait_idle("t6_idle_end", 60);

      // Two-floor build
      req2 = 2'b10;
      @(negedge clk);
      req2 = '0;
      first_arr = -1;
      for (int k = 2; k < 40; k++) begin
         @(negedge clk);
         if (k < 20) req2 = 2'b10;
         else req2 = '0;
         if (arr2 && first_arr < 0) first_arr = k;
      end
      req2 = '0;
      repeat (12) @(negedge clk);
      check("f2_arrive_clk", first_arr, 6);
      check("f2_floor", int'(floor2), 1);
      check("f2_max_floor", max2, 1);
      check("f2_dir", int'(dir2), 0);
      check("f2_pending", int'(pend2), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish by %0t expected bench completion", $time);
      $fatal(1, "timeout");
   end

endmodule
